ad7124_measure_scheduler: RTL and testbench

Sequences one complete thermocouple/RTD measurement across all GX AD boards. On a `measure_start` handshake it pulses the AD7124 SYNC lines, then steps through every TC channel and finally the RTD channel. For each step it issues read requests to the per-board SPI engines in parallel, collects the results with a timeout, and streams timestamped results to the register/IRQ layer. It sits between the measure-control handshake and the per-board SPI engines inside the AD7124 v2 IP.

---
 rtl/ad7124_v2_pkg.sv | 20 ++
 rtl/ad7124_measure_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_ad7124_measure_scheduler.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ad7124_v2_pkg.sv
// Shared definitions for the AD7124 v2 measurement path.
package ad7124_v2_pkg;

  localparam int AD7124_DATA_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_ISSUE,
    ST_WAIT,
    ST_DRAIN,
    ST_DONE
  } meas_state_e;

  // The RTD is read as the step right after the last TC channel.
  function automatic int unsigned rtd_step(input int unsigned num_tc);
    return num_tc;
  endfunction

endpackage

// File: rtl/ad7124_measure_scheduler.sv
// Sequences one TC/RTD measurement over all enabled GX boards: SYNC pulse,
// then per step a parallel read on every enabled board, a bounded wait for
// the acks, and an in-order drain of timestamped results.
//
// Handshakes: measure_start is accepted on a cycle where measure_ready is
// high (IDLE); spi_req/spi_ack are single-cycle strobes with no
// backpressure, and res_valid is a single-cycle strobe with no backpressure.
module ad7124_measure_scheduler
  import ad7124_v2_pkg::*;
#(
  parameter int NUM_OF_BOARD        = 6,
  parameter int NUM_OF_TC_PER_BOARD = 8,
  parameter int SYNC_CYCLES         = 4,
  parameter int TIMEOUT_CYCLES      = 1000000
) (
  input  logic                                       aclk,
  input  logic                                       areset,
  input  logic                                       measure_start,
  output logic                                       measure_ready,
  output logic                                       measure_done,
  input  logic [NUM_OF_BOARD-1:0]                    board_en,
  input  logic [31:0]                                rtc_sec,
  input  logic [31:0]                                rtc_nsec,
  output logic [31:0]                                ts_sec,
  output logic [31:0]                                ts_nsec,
  output logic [NUM_OF_BOARD-1:0]                    GX_ADC_SYNC,
  output logic [NUM_OF_BOARD-1:0]                    spi_req,
  output logic [$clog2(NUM_OF_TC_PER_BOARD+1)-1:0]   spi_sel,
  input  logic [NUM_OF_BOARD-1:0]                    spi_ack,
  input  logic [AD7124_DATA_W*NUM_OF_BOARD-1:0]      spi_data,
  output logic                                       res_valid,
  output logic [$clog2(NUM_OF_BOARD)-1:0]            res_board,
  output logic [$clog2(NUM_OF_TC_PER_BOARD+1)-1:0]   res_chan,
  output logic [AD7124_DATA_W-1:0]                   res_data,
  output logic                                       res_err,
  output logic [NUM_OF_BOARD-1:0]                    timeout_flags,
  output logic [2:0]                                 dbg_state
);

  localparam int NB    = NUM_OF_BOARD;
  localparam int DW    = AD7124_DATA_W;
  localparam int CH_W  = $clog2(NUM_OF_TC_PER_BOARD + 1);
  localparam int BRD_W = $clog2(NUM_OF_BOARD);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam int SYN_W = $clog2(SYNC_CYCLES + 1);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SYN_W-1:0] SYN_LAST = SYN_W'(SYNC_CYCLES - 1);
  localparam logic [CH_W-1:0]  CH_RTD   = CH_W'(rtd_step(NUM_OF_TC_PER_BOARD));

  meas_state_e      state;
  logic [NB-1:0]    en;
  logic [CH_W-1:0]  chan;
  logic [NB-1:0]    pending;
  logic [NB-1:0]    err;
  logic [NB-1:0]    left;      // boards still to drain after the one on res_*
  logic [TMR_W-1:0] timer;
  logic [SYN_W-1:0] sync_cnt;
  logic [DW-1:0]    data_buf [NB];

  logic [NB-1:0]    ack_hit;
  logic [NB-1:0]    pend_after;
  logic             tmo;
  logic [NB-1:0]    err_n;
  logic [DW-1:0]    buf_n [NB];
  logic [NB-1:0]    drain_mask;
  logic [BRD_W-1:0] pick_idx;
  logic [NB-1:0]    pick_bit;
  logic             emit;

  assign dbg_state = state;

  // Merge this cycle's acks so the first result can leave on the WAIT exit edge.
  always_comb begin
    ack_hit    = (state == ST_WAIT) ? (spi_ack & pending) : '0;
    pend_after = pending & ~ack_hit;
    tmo        = (state == ST_WAIT) && (pend_after != '0) && (timer == TMR_LAST);
    err_n      = tmo ? (err | pend_after) : err;
    for (int b = 0; b < NB; b++) begin
      buf_n[b] = ack_hit[b] ? spi_data[b*DW +: DW] : data_buf[b];
    end
    drain_mask = (state == ST_WAIT) ? en : left;
    pick_idx   = '0;
    for (int b = NB - 1; b >= 0; b--) begin
      if (drain_mask[b]) pick_idx = BRD_W'(b);
    end
    pick_bit = NB'(1) << pick_idx;
    emit     = ((state == ST_WAIT) && ((pend_after == '0) || tmo)) ||
               ((state == ST_DRAIN) && (left != '0));
  end

  // Measurement sequencer with registered outputs.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= ST_IDLE;
      en            <= '0;
      chan          <= '0;
      pending       <= '0;
      err           <= '0;
      left          <= '0;
      timer         <= '0;
      sync_cnt      <= '0;
      for (int b = 0; b < NB; b++) data_buf[b] <= '0;
      measure_ready <= 1'b1;
      measure_done  <= 1'b0;
      ts_sec        <= '0;
      ts_nsec       <= '0;
      GX_ADC_SYNC   <= '1;
      spi_req       <= '0;
      spi_sel       <= '0;
      res_valid     <= 1'b0;
      res_board     <= '0;
      res_chan      <= '0;
      res_data      <= '0;
      res_err       <= 1'b0;
      timeout_flags <= '0;
    end else begin
      measure_done <= 1'b0;
      res_valid    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (measure_start) begin
            en            <= board_en;
            ts_sec        <= rtc_sec;
            ts_nsec       <= rtc_nsec;
            timeout_flags <= '0;
            chan          <= '0;
            measure_ready <= 1'b0;
            if (board_en == '0) begin
              measure_done <= 1'b1;
              state        <= ST_DONE;
            end else begin
              GX_ADC_SYNC <= ~board_en;
              sync_cnt    <= '0;
              state       <= ST_SYNC;
            end
          end
        end
        ST_SYNC: begin
          if (sync_cnt == SYN_LAST) begin
            GX_ADC_SYNC <= '1;
            spi_req     <= en;
            spi_sel     <= chan;
            state       <= ST_ISSUE;
          end else begin
            sync_cnt <= sync_cnt + 1'b1;
          end
        end
        ST_ISSUE: begin
          spi_req <= '0;
          pending <= en;
          err     <= '0;
          timer   <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          data_buf <= buf_n;
          if ((pend_after == '0) || tmo) begin
            pending       <= '0;
            err           <= err_n;
            timeout_flags <= timeout_flags | err_n;
            state         <= ST_DRAIN;
          end else begin
            pending <= pend_after;
            timer   <= timer + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (left == '0) begin
            if (chan == CH_RTD) begin
              measure_done <= 1'b1;
              state        <= ST_DONE;
            end else begin
              chan    <= chan + 1'b1;
              spi_req <= en;
              spi_sel <= chan + 1'b1;
              state   <= ST_ISSUE;
            end
          end
        end
        ST_DONE: begin
          measure_ready <= 1'b1;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (emit) begin
        res_valid <= 1'b1;
        res_board <= pick_idx;
        res_chan  <= chan;
        res_err   <= err_n[pick_idx];
        res_data  <= err_n[pick_idx] ? '0 : buf_n[pick_idx];
        left      <= drain_mask & ~pick_bit;
      end
    end
  end

endmodule

// File: tb/tb_ad7124_measure_scheduler.sv
// Bench for ad7124_measure_scheduler: directed measurements with an SPI
// responder, a queue-based result model and hand-computed timing literals.
module tb_ad7124_measure_scheduler;

  localparam int NB   = 6;
  localparam int NTC  = 8;
  localparam int SYNC = 4;
  localparam int TMO  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic areset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT ----------------
  logic          measure_start = 1'b0;
  logic          measure_ready, measure_done;
  logic [NB-1:0] board_en = '0;
  logic [31:0]   rtc_sec = '0, rtc_nsec = '0;
  logic [31:0]   ts_sec, ts_nsec;
  logic [NB-1:0] GX_ADC_SYNC, spi_req, spi_ack = '0;
  logic [3:0]    spi_sel, res_chan;
  logic [24*NB-1:0] spi_data = '0;
  logic          res_valid, res_err;
  logic [2:0]    res_board, dbg_state;
  logic [23:0]   res_data;
  logic [NB-1:0] timeout_flags;

  ad7124_measure_scheduler #(
    .NUM_OF_BOARD(NB), .NUM_OF_TC_PER_BOARD(NTC),
    .SYNC_CYCLES(SYNC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .aclk(clk), .areset(areset), .measure_start(measure_start),
    .measure_ready(measure_ready), .measure_done(measure_done),
    .board_en(board_en), .rtc_sec(rtc_sec), .rtc_nsec(rtc_nsec),
    .ts_sec(ts_sec), .ts_nsec(ts_nsec), .GX_ADC_SYNC(GX_ADC_SYNC),
    .spi_req(spi_req), .spi_sel(spi_sel), .spi_ack(spi_ack),
    .spi_data(spi_data), .res_valid(res_valid), .res_board(res_board),
    .res_chan(res_chan), .res_data(res_data), .res_err(res_err),
    .timeout_flags(timeout_flags), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  logic [NB-1:0] cfg_noack = '0;   // boards whose engine never answers
  logic [NB-1:0] spur_mask = '0;   // boards that ack every cycle regardless
  logic [NB-1:0] cur_en, sync_en, flags_exp;
  int sync_left = 0, exp_sel = 0;
  int accept_cyc = 0, n_accept = 0, n_done = 0, res_cnt = 0;
  int first_req_rel = -1, first_res_rel = -1, done_rel = -1, ready_rel = -1;
  bit ready_next_chk = 0;
  logic [31:0] last_res = '0;
  int low_cnt [NB];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: got event-missing expected event (t=%0t)", name, $time);
  endtask

  // Value returned by an engine for board b at step ch.
  function automatic logic [23:0] pat(input int b, input int ch);
    logic [3:0] bb, cc;
    bb = 4'(b);
    cc = 4'(ch);
    return {4'hC, bb, 4'h0, cc, 8'hA5};
  endfunction

  // ---------------- SPI engine responder ----------------
  logic [NB-1:0] next_ack = '0;
  logic [3:0]    lat_sel = '0;
  always @(negedge clk) begin
    spi_ack = next_ack | spur_mask;
    for (int b = 0; b < NB; b++) begin
      if (next_ack[b]) spi_data[b*24 +: 24] = pat(b, int'(lat_sel));
      else if (spur_mask[b]) spi_data[b*24 +: 24] = 24'hBADBAD;
    end
    next_ack = areset ? '0 : (spi_req & ~cfg_noack);
    lat_sel  = spi_sel;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    logic [NB-1:0] t;
    if (areset) begin
      exp_q.delete();
      sync_left = 0;
      ready_next_chk = 0;
    end else begin
      for (int b = 0; b < NB; b++) if (!GX_ADC_SYNC[b]) low_cnt[b]++;
      if (sync_left > 0) begin
        t = ~sync_en;
        check("sync_low", GX_ADC_SYNC, t);
        sync_left--;
      end else begin
        t = '1;
        check("sync_high", GX_ADC_SYNC, t);
      end
      if (ready_next_chk) begin
        check("ready_after_done", measure_ready, 1);
        ready_rel = cyc - accept_cyc;
        ready_next_chk = 0;
      end
      if (measure_ready && measure_start) begin
        accept_cyc = cyc;
        n_accept++;
        cur_en = board_en;
        sync_en = board_en;
        sync_left = (board_en != '0) ? SYNC : 0;
        flags_exp = board_en & cfg_noack;
        exp_sel = 0; res_cnt = 0;
        first_req_rel = -1; first_res_rel = -1; done_rel = -1;
        for (int b = 0; b < NB; b++) low_cnt[b] = 0;
        for (int ch = 0; ch <= NTC; ch++)
          for (int b = 0; b < NB; b++)
            if (board_en[b])
              exp_q.push_back({3'(b), 4'(ch), cfg_noack[b],
                               cfg_noack[b] ? 24'h0 : pat(b, ch)});
      end
      if (spi_req != '0) begin
        if (first_req_rel < 0) first_req_rel = cyc - accept_cyc;
        check("req_mask", spi_req, cur_en);
        check("req_sel", spi_sel, exp_sel);
        exp_sel++;
      end
      if (res_valid) begin
        res_cnt++;
        if (first_res_rel < 0) first_res_rel = cyc - accept_cyc;
        check("busy_on_res", measure_ready, 0);
        last_res = {res_board, res_chan, res_err, res_data};
        if (exp_q.size() == 0) fail("res_unexpected");
        else begin
          e = exp_q.pop_front();
          check("res", {res_board, res_chan, res_err, res_data}, e);
        end
      end
      if (measure_done) begin
        n_done++;
        done_rel = cyc - accept_cyc;
        check("done_q_empty", exp_q.size(), 0);
        check("done_flags", timeout_flags, flags_exp);
        check("busy_on_done", measure_ready, 0);
        ready_next_chk = 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run(input logic [NB-1:0] en, input logic [NB-1:0] noack,
                     input int n_meas, input bit hold);
    int base_done, base_acc;
    base_done = n_done;
    base_acc  = n_accept;
    board_en  = en;
    cfg_noack = noack;
    @(posedge clk); #2;
    measure_start = 1'b1;
    if (!hold) begin
      for (int i = 0; i < 20 && n_accept == base_acc; i++) begin @(posedge clk); #2; end
      if (n_accept == base_acc) fail("accept_timeout");
      measure_start = 1'b0;
    end
    for (int i = 0; i < 5000 && n_done < base_done + n_meas; i++) begin @(posedge clk); #2; end
    if (n_done < base_done + n_meas) fail("done_timeout");
    measure_start = 1'b0;
    repeat (3) begin @(posedge clk); #2; end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    fail("watchdog");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // ---------------- directed tests ----------------
  initial begin
    int acc0, nd;
    repeat (3) @(posedge clk);
    #2;
    check("rst_ready", measure_ready, 1);
    check("rst_done", measure_done, 0);
    check("rst_sync", GX_ADC_SYNC, 6'h3F);
    check("rst_req", spi_req, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_ts_sec", ts_sec, 0);
    check("rst_flags", timeout_flags, 0);
    areset = 1'b0;
    repeat (2) begin @(posedge clk); #2; end

    // 1: all boards, immediate acks
    rtc_sec = 32'h1111_0001; rtc_nsec = 32'h0000_0100;
    run(6'h3F, 6'h00, 1, 0);
    check("t1_res_cnt", res_cnt, 54);
    check("t1_first_req", first_req_rel, 5);
    check("t1_first_res", first_res_rel, 7);
    check("t1_done", done_rel, 77);
    check("t1_ready", ready_rel, 78);
    check("t1_last_res", last_res, {3'd5, 4'd8, 1'b0, 24'hC508A5});

    // 2: boards 0 and 2 only
    run(6'b000101, 6'h00, 1, 0);
    check("t2_res_cnt", res_cnt, 18);
    check("t2_first_req", first_req_rel, 5);
    check("t2_done", done_rel, 41);
    check("t2_sync_b0", low_cnt[0], 4);
    check("t2_sync_b1", low_cnt[1], 0);
    check("t2_sync_b2", low_cnt[2], 4);

    // 3: board 3 silent, every step times out
    run(6'h3F, 6'b001000, 1, 0);
    check("t3_res_cnt", res_cnt, 54);
    check("t3_first_res", first_res_rel, 22);
    check("t3_done", done_rel, 212);
    check("t3_flags", timeout_flags, 6'b001000);
    check("t3_last_res", last_res, {3'd5, 4'd8, 1'b0, 24'hC508A5});

    // 4: start held high, spurious acks on disabled boards
    spur_mask = 6'b101100;
    acc0 = n_accept;
    run(6'b010011, 6'h00, 2, 1);
    check("t4_accepts", n_accept - acc0, 2);
    check("t4_res_cnt", res_cnt, 27);
    check("t4_done", done_rel, 50);
    spur_mask = '0;
    repeat (4) begin @(posedge clk); #2; end
    check("t4_no_extra", n_accept - acc0, 2);

    // 5: reset in the WAIT of step 4
    board_en = 6'h3F; cfg_noack = 6'b000001;
    measure_start = 1'b1;
    @(posedge clk); #2;
    measure_start = 1'b0;
    for (int i = 0; i < 2000 && !((spi_req != '0) && (spi_sel == 4'd4)); i++) begin
      @(posedge clk); #2;
    end
    if (!((spi_req != '0) && (spi_sel == 4'd4))) fail("t5_step4_timeout");
    repeat (4) begin @(posedge clk); #2; end
    nd = n_done;
    areset = 1'b1;
    @(posedge clk); #2;
    check("t5_ready", measure_ready, 1);
    check("t5_sync", GX_ADC_SYNC, 6'h3F);
    check("t5_done", measure_done, 0);
    check("t5_req", spi_req, 0);
    check("t5_res_valid", res_valid, 0);
    check("t5_flags", timeout_flags, 0);
    areset = 1'b0;
    repeat (5) begin @(posedge clk); #2; end
    check("t5_no_done", n_done, nd);
    run(6'h3F, 6'h00, 1, 0);
    check("t5_restart_req", first_req_rel, 5);
    check("t5_restart_cnt", res_cnt, 54);
    check("t5_restart_done", done_rel, 77);

    // 6: empty enable mask
    rtc_sec = 32'hCAFE_0006; rtc_nsec = 32'h0000_1234;
    run(6'h00, 6'h00, 1, 0);
    rtc_sec = 32'h0; rtc_nsec = 32'h0;
    @(posedge clk); #2;
    check("t6_done", done_rel, 1);
    check("t6_ready", ready_rel, 2);
    check("t6_res_cnt", res_cnt, 0);
    check("t6_ts_sec", ts_sec, 32'hCAFE_0006);
    check("t6_ts_nsec", ts_nsec, 32'h0000_1234);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
